// File: rtl/debounce_pkg.sv
// Shared types and default constants for the multi-channel button debouncer.
package debounce_pkg;

    // One-hot style encoding so that a corrupted state register is detectable
    // and recovered through the FSM default arm.
    typedef enum logic [1:0] {
        ST_STABLE  = 2'b01,
        ST_PENDING = 2'b10
    } deb_state_t;

    // 10 ms debounce window and 2 s long-press at a 50 MHz system clock.
    localparam int unsigned DEB_DEFAULT_CYCLES = 32'd500_000;
    localparam int unsigned DEB_DEFAULT_LONG   = 32'd100_000_000;

endpackage

// File: rtl/debounce_channel.sv
// Single button channel: 2-flop synchroniser, symmetric press/release debounce
// FSM, registered press/release pulses and, when MULTI_DEBOUNCE_LONGPRESS_EN is
// defined, a saturating hold counter producing one long-press pulse per press.
// "release" is a reserved word, so the falling-edge pulse is release_pulse.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEB_DEFAULT_CYCLES
`ifdef MULTI_DEBOUNCE_LONGPRESS_EN
    ,
    parameter int unsigned LONG_CYCLES     = DEB_DEFAULT_LONG
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic long_press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]    sync_r;
    logic          s_s;
    deb_state_t    state_r;
    logic [CW-1:0] cnt_r;
    logic          level_r;
    logic          press_r;
    logic          release_r;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], btn};
        end
    end

    assign s_s = sync_r[1];

    // Debounce FSM: a change is accepted only after DEBOUNCE_CYCLES
    // consecutive synchronised samples disagree with the current level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_STABLE;
            cnt_r     <= {CW{1'b0}};
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            press_r   <= 1'b0;
            release_r <= 1'b0;
            case (state_r)
                ST_STABLE: begin
                    if (s_s != level_r) begin
                        state_r <= ST_PENDING;
                        cnt_r   <= CW'(1);
                    end else begin
                        cnt_r   <= {CW{1'b0}};
                    end
                end
                ST_PENDING: begin
                    if (s_s == level_r) begin
                        state_r <= ST_STABLE;
                        cnt_r   <= {CW{1'b0}};
                    end else if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
                        level_r   <= ~level_r;
                        press_r   <= ~level_r;
                        release_r <= level_r;
                        state_r   <= ST_STABLE;
                        cnt_r     <= {CW{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= ST_STABLE;
                    cnt_r   <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign level         = level_r;
    assign press         = press_r;
    assign release_pulse = release_r;

`ifdef MULTI_DEBOUNCE_LONGPRESS_EN
    localparam int unsigned HW = $clog2(LONG_CYCLES);

    logic [HW-1:0] hold_r;
    logic          long_r;
    logic          fall_s;

    // Level is about to drop this edge; a release on this edge beats long-press.
    always_comb begin
        if ((state_r == ST_PENDING) && (s_s != level_r) &&
            (cnt_r == CW'(DEBOUNCE_CYCLES - 1))) begin
            fall_s = level_r;
        end else begin
            fall_s = 1'b0;
        end
    end

    // Count accepted-pressed cycles, pulse once at LONG_CYCLES-1 and saturate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_r <= {HW{1'b0}};
            long_r <= 1'b0;
        end else begin
            long_r <= 1'b0;
            if (!level_r) begin
                hold_r <= {HW{1'b0}};
            end else if (hold_r != HW'(LONG_CYCLES - 1)) begin
                hold_r <= hold_r + HW'(1);
                if ((hold_r == HW'(LONG_CYCLES - 2)) && !fall_s) begin
                    long_r <= 1'b1;
                end else begin
                    long_r <= 1'b0;
                end
            end else begin
                hold_r <= hold_r;
            end
        end
    end

    assign long_press = long_r;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: rtl/multi_button_debounce.sv
// N-channel push-button conditioner: one independent debounce_channel per
// button. Long-press detection is compiled in only when the macro
// MULTI_DEBOUNCE_LONGPRESS_EN is defined; otherwise long_press is tied low.
module multi_button_debounce
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH            = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEB_DEFAULT_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEB_DEFAULT_LONG
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] btn,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_press
);

    // Reject parameter values the channel logic cannot represent.
    if ((N_CH < 1) || (DEBOUNCE_CYCLES < 2) || (LONG_CYCLES < 2)) begin : g_param_check
        $error("multi_button_debounce: parameter out of range");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef MULTI_DEBOUNCE_LONGPRESS_EN
            ,
            .LONG_CYCLES     (LONG_CYCLES)
`endif
        ) u_channel (
            .clk           (clk),
            .reset         (reset),
            .btn           (btn[i]),
            .level         (level[i]),
            .press         (press[i]),
            .release_pulse (release_pulse[i]),
            .long_press    (long_press[i])
        );
    end

endmodule
